// File: rtl/uart_rx_fifo_if.sv
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receiver / CPU-side bus bundle for uart_rx_fifo.
//               Optional macro: RX_FIFO_PARITY_TAG_EN (adds RX_PERR use, DOUT_PERR)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          RX_DATA;
  logic                RX_RDY;
  logic                RX_PERR;
  logic                RDY_CLR;
  logic                RD_EN;
  logic [7:0]          DOUT;
  logic                EMPTY;
  logic                FULL;
  logic [DEPTH_LOG2:0] COUNT;
  logic                OVERRUN;
  logic                OVR_CLR;
  logic                INT;
`ifdef RX_FIFO_PARITY_TAG_EN
  logic                DOUT_PERR;

  modport master (
    output RX_DATA, RX_RDY, RX_PERR, RD_EN, OVR_CLR,
    input  RDY_CLR, DOUT, DOUT_PERR, EMPTY, FULL, COUNT, OVERRUN, INT
  );

  modport slave (
    input  RX_DATA, RX_RDY, RX_PERR, RD_EN, OVR_CLR,
    output RDY_CLR, DOUT, DOUT_PERR, EMPTY, FULL, COUNT, OVERRUN, INT
  );
`else
  modport master (
    output RX_DATA, RX_RDY, RX_PERR, RD_EN, OVR_CLR,
    input  RDY_CLR, DOUT, EMPTY, FULL, COUNT, OVERRUN, INT
  );

  // The parity flag has no consumer in the untagged build.
  modport slave (
    input  RX_DATA, RX_RDY, RD_EN, OVR_CLR,
    output RDY_CLR, DOUT, EMPTY, FULL, COUNT, OVERRUN, INT
  );
`endif

endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive capture handshake + first-word-fall-through FIFO
//               with level/overrun interrupt. Optional macro:
//               RX_FIFO_PARITY_TAG_EN (stores RX_PERR tag per entry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH     = 8
) (
  input  wire logic          CLK50M,
  input  wire logic          RST,
  uart_rx_fifo_if.slave      bus
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;
`ifdef RX_FIFO_PARITY_TAG_EN
  localparam int c_W = 9;
`else
  localparam int c_W = 8;
`endif
  localparam logic [DEPTH_LOG2:0] c_THRESH = (DEPTH_LOG2 + 1)'(THRESH);
  localparam logic [DEPTH_LOG2:0] c_FULL_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ACK  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_capture;
  logic                  w_rdy_clr;

  logic [c_W-1:0]        r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   r_count;
  logic [c_W-1:0]        r_dout;
  logic [c_W-1:0]        w_head_nxt;
  logic [c_W-1:0]        w_entry;
  logic                  r_overrun;
  logic                  r_int;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_ovr_set;

  // ---------------------------------------------------------------- capture FSM
  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (bus.RX_RDY) w_state_nxt = c_ST_ACK;
      c_ST_ACK:  w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: if (!bus.RX_RDY) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_rdy_clr = 1'b0;
    case (r_state)
      c_ST_IDLE: w_capture = bus.RX_RDY;
      c_ST_ACK:  w_rdy_clr = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------- FIFO core
`ifdef RX_FIFO_PARITY_TAG_EN
  assign w_entry = {bus.RX_PERR, bus.RX_DATA};
`else
  assign w_entry = bus.RX_DATA;
`endif

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL_CNT);
  assign w_wr      = w_capture & ~w_full;
  assign w_ovr_set = w_capture &  w_full;
  assign w_rd      = bus.RD_EN & ~w_empty;

  assign w_rd_ptr_nxt = r_rd_ptr + DEPTH_LOG2'(w_rd);

  // When the slot being written becomes the new head, bypass the memory.
  assign w_head_nxt = (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) ? w_entry
                                                           : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge CLK50M) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dout    <= '0;
      r_overrun <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr || w_rd) begin
        r_dout <= w_head_nxt;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (bus.OVR_CLR) begin
        r_overrun <= 1'b0;
      end
      r_int <= (r_count >= c_THRESH) | r_overrun;
    end
  end

  assign bus.RDY_CLR = w_rdy_clr;
  assign bus.DOUT    = r_dout[7:0];
  assign bus.EMPTY   = w_empty;
  assign bus.FULL    = w_full;
  assign bus.COUNT   = r_count;
  assign bus.OVERRUN = r_overrun;
  assign bus.INT     = r_int;
`ifdef RX_FIFO_PARITY_TAG_EN
  assign bus.DOUT_PERR = r_dout[8];
`endif

endmodule

`default_nettype wire
